// File: rtl/cv32e40px_x_disp_mt.sv
// cv32e40px X-interface dispatcher with multiple outstanding offloads.
// In-flight table feeds the scoreboard; commit follows issue by one cycle.
module cv32e40px_x_disp_mt #(
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned X_DUALWRITE = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       issue_req_i,
    input  logic [4:0]                 issue_rd_i,
    input  logic [2:0][4:0]            rs_addr_i,
    input  logic [2:0]                 regs_used_i,
    input  logic                       id_ready_i,
    input  logic                       kill_i,
    input  logic                       ex_ready_i,
    output logic                       x_issue_valid_o,
    input  logic                       x_issue_ready_i,
    output logic [ID_WIDTH-1:0]        x_issue_req_id_o,
    input  logic                       x_issue_resp_accept_i,
    input  logic                       x_issue_resp_writeback_i,
    input  logic                       x_issue_resp_dualwrite_i,
    input  logic                       x_issue_resp_loadstore_i,
    output logic                       x_commit_valid_o,
    output logic [ID_WIDTH-1:0]        x_commit_id_o,
    output logic                       x_commit_commit_kill_o,
    input  logic                       x_mem_valid_i,
    output logic                       x_mem_ready_o,
    output logic                       x_mem_data_req_o,
    input  logic                       x_result_valid_i,
    output logic                       x_result_ready_o,
    input  logic [ID_WIDTH-1:0]        x_result_id_i,
    input  logic [4:0]                 x_result_rd_i,
    input  logic [X_DUALWRITE:0]       x_result_we_i,
    output logic                       x_stall_o,
    output logic                       x_illegal_insn_o,
    output logic                       protocol_err_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]    ent_valid_q;
    logic [ID_WIDTH-1:0] ent_id_q [DEPTH];
    logic [31:0]         ent_rd_q [DEPTH];
    logic [DEPTH-1:0]    ent_mem_q;

    logic [ID_WIDTH-1:0] id_q;
    logic                issued_q;
    logic                illegal_q;
    logic                err_q;
    logic                commit_valid_q;
    logic [ID_WIDTH-1:0] commit_id_q;
    logic [IDX_W-1:0]    commit_idx_q;

    logic [31:0]      scoreboard;
    logic [CNT_W-1:0] count;
    logic             dep;
    logic             waw;
    logic             full;
    logic             hs;
    logic             hs_acc;
    logic [IDX_W-1:0] alloc_idx;
    logic [31:0]      new_mask;
    logic [DEPTH-1:0] free_vec;
    logic             res_hit;

    always_comb begin
        scoreboard = '0;
        count      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_q[i]) begin
                scoreboard = scoreboard | ent_rd_q[i];
            end
            count = count + CNT_W'(ent_valid_q[i]);
        end
    end

    always_comb begin
        dep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (regs_used_i[i]) begin
                dep = dep | scoreboard[rs_addr_i[i]];
                if (X_DUALWRITE != 0) begin
                    dep = dep | scoreboard[{rs_addr_i[i][4:1], 1'b1}];
                end
            end
        end
    end

    assign waw  = (issue_rd_i != 5'd0) & scoreboard[issue_rd_i];
    assign full = (count == CNT_W'(DEPTH));

    assign x_issue_valid_o = issue_req_i & ~issued_q & ~dep & ~waw & ~full;
    assign hs              = x_issue_valid_o & x_issue_ready_i;
    assign hs_acc          = hs & x_issue_resp_accept_i;
    assign x_stall_o       = issue_req_i & ~issued_q & ~hs;

    // Lowest free slot; never used when full since issue is then blocked.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid_q[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        new_mask = '0;
        if (x_issue_resp_writeback_i && (issue_rd_i != 5'd0)) begin
            new_mask[issue_rd_i] = 1'b1;
            if ((X_DUALWRITE != 0) && x_issue_resp_dualwrite_i) begin
                new_mask[{issue_rd_i[4:1], 1'b1}] = 1'b1;
            end
        end
    end

    // Kill and result can name the same entry; clearing twice is harmless.
    always_comb begin
        free_vec = '0;
        res_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (x_result_valid_i && ent_valid_q[i] &&
                (ent_id_q[i] == x_result_id_i)) begin
                free_vec[i] = 1'b1;
                res_hit     = 1'b1;
            end
            if (commit_valid_q && kill_i && (commit_idx_q == IDX_W'(i))) begin
                free_vec[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_valid_q <= '0;
            ent_mem_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_id_q[i] <= '0;
                ent_rd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (free_vec[i]) begin
                    ent_valid_q[i] <= 1'b0;
                end
            end
            if (hs_acc) begin
                ent_valid_q[alloc_idx] <= 1'b1;
                ent_id_q[alloc_idx]    <= id_q;
                ent_rd_q[alloc_idx]    <= new_mask;
                ent_mem_q[alloc_idx]   <= x_issue_resp_loadstore_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q           <= '0;
            issued_q       <= 1'b0;
            illegal_q      <= 1'b0;
            err_q          <= 1'b0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            commit_idx_q   <= '0;
        end else begin
            if (id_ready_i) begin
                issued_q <= 1'b0;
            end else if (hs) begin
                issued_q <= 1'b1;
            end
            illegal_q      <= hs & ~x_issue_resp_accept_i;
            err_q          <= x_result_valid_i & ~res_hit;
            commit_valid_q <= hs_acc;
            if (hs_acc) begin
                id_q         <= id_q + ID_WIDTH'(1);
                commit_id_q  <= id_q;
                commit_idx_q <= alloc_idx;
            end
        end
    end

    assign x_issue_req_id_o       = id_q;
    assign x_commit_valid_o       = commit_valid_q;
    assign x_commit_id_o          = commit_id_q;
    assign x_commit_commit_kill_o = commit_valid_q & kill_i;
    assign x_illegal_insn_o       = illegal_q;
    assign protocol_err_o         = err_q;
    assign outstanding_o          = count;
    assign x_result_ready_o       = 1'b1;
    assign x_mem_ready_o          = ex_ready_i;
    assign x_mem_data_req_o       = x_mem_valid_i & ex_ready_i;

    logic unused_sigs;
    assign unused_sigs = ^{x_result_rd_i, x_result_we_i, ent_mem_q};

endmodule

// File: tb/tb_cv32e40px_x_disp_mt.sv
// Bench for cv32e40px_x_disp_mt: directed scenarios plus random traffic
// checked every cycle against a queue-based model of in-flight offloads.
module tb_cv32e40px_x_disp_mt;

    localparam int IW = 4;
    localparam int D  = 4;
    localparam int DW = 1;

    logic clk;
    logic rst;
    logic req;
    logic [4:0] rd;
    logic [2:0][4:0] rs_addr;
    logic [2:0] used;
    logic id_ready;
    logic kill;
    logic ex_ready;
    logic iss_valid;
    logic iss_ready;
    logic [IW-1:0] req_id;
    logic acc;
    logic wb;
    logic dual;
    logic ls;
    logic cv;
    logic [IW-1:0] cid;
    logic ckill;
    logic mem_valid;
    logic mem_ready;
    logic mem_dreq;
    logic res_valid;
    logic res_ready;
    logic [IW-1:0] res_id;
    logic [4:0] res_rd;
    logic [DW:0] res_we;
    logic stall;
    logic ill;
    logic perr;
    logic [$clog2(D+1)-1:0] outst;

    cv32e40px_x_disp_mt #(
        .ID_WIDTH(IW), .DEPTH(D), .X_DUALWRITE(DW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .issue_req_i(req), .issue_rd_i(rd),
        .rs_addr_i(rs_addr), .regs_used_i(used),
        .id_ready_i(id_ready), .kill_i(kill), .ex_ready_i(ex_ready),
        .x_issue_valid_o(iss_valid), .x_issue_ready_i(iss_ready),
        .x_issue_req_id_o(req_id),
        .x_issue_resp_accept_i(acc),
        .x_issue_resp_writeback_i(wb),
        .x_issue_resp_dualwrite_i(dual),
        .x_issue_resp_loadstore_i(ls),
        .x_commit_valid_o(cv), .x_commit_id_o(cid),
        .x_commit_commit_kill_o(ckill),
        .x_mem_valid_i(mem_valid), .x_mem_ready_o(mem_ready),
        .x_mem_data_req_o(mem_dreq),
        .x_result_valid_i(res_valid), .x_result_ready_o(res_ready),
        .x_result_id_i(res_id), .x_result_rd_i(res_rd),
        .x_result_we_i(res_we),
        .x_stall_o(stall), .x_illegal_insn_o(ill),
        .protocol_err_o(perr), .outstanding_o(outst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   mask;
    } ent_t;

    ent_t q[$];
    int   m_id;
    bit   m_issued;
    bit   m_ill;
    bit   m_err;
    bit   m_cv;
    int   m_cid;
    int   n_cmp;
    int   n_err;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 0; req = 0; rd = 0; rs_addr = '0; used = 0;
        id_ready = 0; kill = 0; ex_ready = 0; iss_ready = 0;
        acc = 0; wb = 0; dual = 0; ls = 0; mem_valid = 0;
        res_valid = 0; res_id = 0; res_rd = 0; res_we = 0;
    endtask

    task automatic cyc();
        logic [31:0] sb;
        logic [31:0] mask;
        bit dep, waw, full, v, hs, found, kf;
        ent_t nq[$];
        @(negedge clk);
        sb = 0;
        foreach (q[k]) sb = sb | q[k].mask;
        dep = 0;
        for (int i = 0; i < 3; i++) begin
            if (used[i]) begin
                dep = dep | sb[rs_addr[i]];
                if (DW != 0) dep = dep | sb[rs_addr[i] | 5'd1];
            end
        end
        waw  = (rd != 0) && sb[rd];
        full = (q.size() == D);
        v    = req && !m_issued && !dep && !waw && !full;
        hs   = v && iss_ready;
        chk("issue_valid", iss_valid, v);
        chk("stall", stall, req && !m_issued && !hs);
        chk("req_id", req_id, m_id);
        chk("commit_valid", cv, m_cv);
        if (m_cv) chk("commit_id", cid, m_cid);
        chk("commit_kill", ckill, m_cv && kill);
        chk("illegal", ill, m_ill);
        chk("proto_err", perr, m_err);
        chk("outstanding", outst, q.size());
        chk("result_ready", res_ready, 1);
        chk("mem_ready", mem_ready, ex_ready);
        chk("mem_data_req", mem_dreq, mem_valid && ex_ready);
        if (rst) begin
            q.delete();
            m_id = 0; m_issued = 0; m_ill = 0; m_err = 0; m_cv = 0;
        end else begin
            kf = m_cv && kill;
            found = 0;
            foreach (q[k]) if (q[k].id == res_id) found = 1;
            foreach (q[k]) begin
                if (!((kf && q[k].id == m_cid[IW-1:0]) ||
                      (res_valid && q[k].id == res_id)))
                    nq.push_back(q[k]);
            end
            q = nq;
            m_err = res_valid && !found;
            m_ill = hs && !acc;
            if (hs && acc) begin
                mask = 0;
                if (wb && rd != 0) begin
                    mask[rd] = 1'b1;
                    if (DW != 0 && dual) mask[rd | 5'd1] = 1'b1;
                end
                q.push_back('{id: m_id[IW-1:0], mask: mask});
                m_cid = m_id;
                m_cv  = 1;
                m_id  = (m_id + 1) % (1 << IW);
            end else begin
                m_cv = 0;
            end
            if (id_ready) m_issued = 0;
            else if (hs) m_issued = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        idle();
        req = 1; rd = r; wb = 1; iss_ready = 1; acc = 1; id_ready = 1;
        cyc();
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cyc();
        idle();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        q.delete();
        m_id = 0; m_issued = 0; m_ill = 0; m_err = 0; m_cv = 0; m_cid = 0;
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_cv", cv, 0);
        chk("rst_out", outst, 0);
        chk("rst_rready", res_ready, 1);
        chk("rst_ill", ill, 0);

        // single writeback offload, then dependent rs1=5
        req = 1; rd = 5; wb = 1; iss_ready = 1; acc = 1; id_ready = 1;
        #1 chk("t1_valid", iss_valid, 1);
        cyc();
        chk("t1_cv", cv, 1);
        chk("t1_cid", cid, 0);
        chk("t1_kill", ckill, 0);
        chk("t1_out", outst, 1);
        id_ready = 0; rd = 6; rs_addr[0] = 5; used = 3'b001;
        #1 chk("dep_valid", iss_valid, 0);
        chk("dep_stall", stall, 1);
        cyc();
        cyc();
        res_valid = 1; res_id = 0;
        #1 chk("dep_hold", iss_valid, 0);
        cyc();
        res_valid = 0;
        #1 chk("dep_resume", iss_valid, 1);
        id_ready = 1;
        cyc();
        chk("dep_cid", cid, 1);

        // fill the table
        do_reset();
        for (int r = 1; r <= 4; r++) issue(5'(r));
        chk("fill_out", outst, 4);
        rd = 10;
        #1 chk("full_valid", iss_valid, 0);
        chk("full_stall", stall, 1);
        res_valid = 1; res_id = 2;
        cyc();
        res_valid = 0;
        #1 chk("free_valid", iss_valid, 1);
        chk("free_id", req_id, 4);
        cyc();
        chk("free_cid", cid, 4);

        // reject
        do_reset();
        req = 1; rd = 3; wb = 1; iss_ready = 1; acc = 0; id_ready = 1;
        cyc();
        chk("rej_ill", ill, 1);
        chk("rej_cv", cv, 0);
        chk("rej_out", outst, 0);
        chk("rej_id", req_id, 0);
        idle();
        cyc();
        chk("rej_ill_end", ill, 0);

        // kill of id 3 (rd=7)
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        issue(5'd7);
        idle();
        kill = 1;
        #1 chk("kill_flag", ckill, 1);
        chk("kill_id", cid, 3);
        cyc();
        kill = 0;
        chk("kill_out", outst, 3);
        req = 1; rd = 7; wb = 1;
        #1 chk("kill_sb7", iss_valid, 1);
        idle();

        // dual write rd=8 -> bits 8,9
        do_reset();
        req = 1; rd = 8; wb = 1; dual = 1; iss_ready = 1; acc = 1; id_ready = 1;
        cyc();
        idle();
        req = 1; rd = 12; rs_addr[0] = 9; used = 3'b001;
        #1 chk("dw_rs9", iss_valid, 0);
        used = 0; rd = 9;
        #1 chk("dw_waw9", iss_valid, 0);
        idle();
        res_valid = 1; res_id = 0;
        cyc();
        idle();
        req = 1; rd = 9; rs_addr[0] = 8; used = 3'b001;
        #1 chk("dw_clear", iss_valid, 1);
        idle();

        // spurious result
        do_reset();
        res_valid = 1; res_id = 6;
        cyc();
        idle();
        chk("perr_set", perr, 1);
        cyc();
        chk("perr_clr", perr, 0);

        // reset mid-flight
        issue(5'd4);
        do_reset();
        chk("mid_cv", cv, 0);
        chk("mid_out", outst, 0);
        chk("mid_valid", iss_valid, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(199) == 0);
            req       = ($urandom_range(9) < 7);
            rd        = 5'($urandom_range(15));
            for (int i = 0; i < 3; i++) rs_addr[i] = 5'($urandom_range(15));
            used      = 3'($urandom);
            id_ready  = ($urandom_range(1) == 1);
            kill      = ($urandom_range(9) < 2);
            ex_ready  = 1'($urandom);
            mem_valid = 1'($urandom);
            iss_ready = ($urandom_range(9) < 8);
            acc       = ($urandom_range(19) < 17);
            wb        = ($urandom_range(9) < 8);
            dual      = ($urandom_range(9) < 3);
            ls        = 1'($urandom);
            res_valid = ($urandom_range(9) < 3);
            if (q.size() > 0 && $urandom_range(9) > 0)
                res_id = q[$urandom_range(q.size() - 1)].id;
            else
                res_id = IW'($urandom);
            res_rd = 5'($urandom);
            res_we = 2'($urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
